rx_sample_pacer: RTL and testbench

RX_SAMPLE_PACER -- requirements
Module: rx_sample_pacer

---
 rtl/rx_pacer_pkg.sv | 19 +
 rtl/sample_fifo.sv | 69 ++++++
 rtl/rx_sample_pacer.sv | 102 ++++++++++
 tb/tb_rx_sample_pacer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pacer_pkg.sv
// Shared constants and helpers for the RX sample pacer.
// Holds the underrun counter width and a ceil-log2 used for pointer and count sizing.
package rx_pacer_pkg;

  localparam int UNDERRUN_W = 16;

  // Returns ceil(log2(value)); value 1 yields 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with push/pop/count; storage is not reset, only pointers and count.
// Pushes while full and pops while empty are ignored internally.
module sample_fifo
  import rx_pacer_pkg::*;
#(
  parameter int data_width_g = 24,
  parameter int depth_g      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic [data_width_g-1:0]   push_data,
  input  logic                      pop,
  output logic [data_width_g-1:0]   head_data,
  output logic [clog2(depth_g):0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = clog2(depth_g);
  localparam logic [AW:0] depth_c = (AW + 1)'(depth_g);
  localparam logic [AW:0] one_c   = (AW + 1)'(1);
  localparam logic [AW-1:0] ptr_one_c = AW'(1);

  logic [data_width_g-1:0] mem [depth_g];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign full      = (count == depth_c);
  assign empty     = (count == '0);
  assign do_push   = push && !full && !clr;
  assign do_pop    = pop && !empty && !clr;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ptr_one_c;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ptr_one_c;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + one_c;
        2'b01:   count <= count - one_c;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_sample_pacer.sv
// Buffers I/Q samples and releases one per strobe tick toward the RX chain,
// counting ticks that find the buffer empty.
module rx_sample_pacer
  import rx_pacer_pkg::*;
#(
  parameter int sample_bit_width_g = 12,
  parameter int fifo_depth_g       = 16,
  parameter int period_width_g     = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rstn,
  input  logic                          sys_init,
  input  logic                          enable,
  input  logic [period_width_g-1:0]     strobe_period,
  input  logic [sample_bit_width_g-1:0] in_i,
  input  logic [sample_bit_width_g-1:0] in_q,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [sample_bit_width_g-1:0] rx_data_i,
  output logic [sample_bit_width_g-1:0] rx_data_q,
  output logic                          rx_data_valid,
  output logic [clog2(fifo_depth_g):0]  fill_level,
  output logic [UNDERRUN_W-1:0]         underrun_cnt
);

  localparam int SW = sample_bit_width_g;
  localparam logic [period_width_g-1:0] period_one_c = period_width_g'(1);
  localparam logic [UNDERRUN_W-1:0]     under_one_c  = UNDERRUN_W'(1);

  logic [period_width_g-1:0] strobe_cnt;
  logic [period_width_g-1:0] period_eff;
  logic [period_width_g-1:0] period_last;
  logic                      tick;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop_taken;
  logic [2*SW-1:0]           head_data;

  // Input handshake: a sample transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready reflects occupancy only, never a same-cycle pop.
  assign in_ready = !fifo_full;

  // A zero period behaves like one; ">=" also fires at once when the period drops below the count.
  assign period_eff  = (strobe_period == '0) ? period_one_c : strobe_period;
  assign period_last = period_eff - period_one_c;
  assign tick        = enable && (strobe_cnt >= period_last);
  assign pop_taken   = tick && !fifo_empty;

  sample_fifo #(
    .data_width_g (2 * SW),
    .depth_g      (fifo_depth_g)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rstn),
    .clr       (sys_init),
    .push      (in_valid),
    .push_data ({in_i, in_q}),
    .pop       (tick),
    .head_data (head_data),
    .count     (fill_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      strobe_cnt <= '0;
    end else if (sys_init || !enable || tick) begin
      strobe_cnt <= '0;
    end else begin
      strobe_cnt <= strobe_cnt + period_one_c;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_data_i     <= '0;
      rx_data_q     <= '0;
      rx_data_valid <= 1'b0;
    end else if (sys_init) begin
      rx_data_valid <= 1'b0;
    end else begin
      rx_data_valid <= pop_taken;
      if (pop_taken) begin
        rx_data_i <= head_data[2*SW-1:SW];
        rx_data_q <= head_data[SW-1:0];
      end
    end
  end

  // An empty tick is an underrun even when a push lands in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      underrun_cnt <= '0;
    end else if (sys_init) begin
      underrun_cnt <= '0;
    end else if (tick && fifo_empty && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + under_one_c;
    end
  end

endmodule

// File: tb/tb_rx_sample_pacer.sv
// Directed bench for rx_sample_pacer: a queue-based model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_rx_sample_pacer;

  localparam int W  = 12;
  localparam int D  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_init = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic [W-1:0]  in_i = '0;
  logic [W-1:0]  in_q = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  rx_data_i;
  logic [W-1:0]  rx_data_q;
  logic          rx_data_valid;
  logic [4:0]    fill_level;
  logic [15:0]   underrun_cnt;

  rx_sample_pacer #(
    .sample_bit_width_g (W),
    .fifo_depth_g       (D),
    .period_width_g     (PW)
  ) dut (
    .sys_clk       (clk),
    .sys_rstn      (rst_n),
    .sys_init      (sys_init),
    .enable        (enable),
    .strobe_period (period),
    .in_i          (in_i),
    .in_q          (in_q),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .rx_data_i     (rx_data_i),
    .rx_data_q     (rx_data_q),
    .rx_data_valid (rx_data_valid),
    .fill_level    (fill_level),
    .underrun_cnt  (underrun_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Samples wait in a queue; a tick happens once enable has been high for
  // max(period,1) cycles since the last tick (or since enable rose).
  logic [2*W-1:0] m_fifo[$];
  int             m_since = 0;
  logic           m_valid = 1'b0;
  logic [W-1:0]   m_i = '0;
  logic [W-1:0]   m_q = '0;
  int             m_under = 0;

  initial begin
    int  p;
    bit  tick;
    bit  accept;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fifo.delete();
        m_since = 0;
        m_valid = 1'b0;
        m_i = '0;
        m_q = '0;
        m_under = 0;
      end else if (sys_init) begin
        m_fifo.delete();
        m_since = 0;
        m_valid = 1'b0;
        m_under = 0;
      end else begin
        p      = (period == 0) ? 1 : int'(period);
        tick   = enable && (m_since + 1 >= p);
        accept = in_valid && (m_fifo.size() < D);
        m_valid = 1'b0;
        if (tick) begin
          if (m_fifo.size() > 0) begin
            {m_i, m_q} = m_fifo.pop_front();
            m_valid = 1'b1;
          end else if (m_under < 65535) begin
            m_under++;
          end
        end
        if (accept) m_fifo.push_back({in_i, in_q});
        m_since = (!enable || tick) ? 0 : m_since + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("valid", 32'(rx_data_valid), 32'(m_valid));
      check("data_i", 32'(rx_data_i), 32'(m_i));
      check("data_q", 32'(rx_data_q), 32'(m_q));
      check("fill", 32'(fill_level), 32'(m_fifo.size()));
      check("in_ready", 32'(in_ready), 32'(m_fifo.size() < D));
      check("underrun", 32'(underrun_cnt), 32'(m_under));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    in_i = v;
    in_q = v ^ 12'hA5A;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic init_pulse();
    sys_init = 1'b1;
    step(1);
    sys_init = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (rx_data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no rx_data_valid within %0d cycles", name, bound);
    end
  endtask

  task automatic count_valids(input int window, output int cnt, output int first, output int last);
    cnt = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < window; k++) begin
      @(negedge clk);
      if (rx_data_valid) begin
        cnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
  endtask

  task automatic burst(input logic [PW-1:0] pv);
    int c;
    int cnt;
    int first;
    int last;
    enable = 1'b0;
    init_pulse();
    period = pv;
    for (int k = 0; k < 8; k++) push(W'(16 + k));
    check("burst_fill8", 32'(fill_level), 32'd8);
    enable = 1'b1;
    c = cyc;
    count_valids(12, cnt, first, last);
    check("burst_count", 32'(cnt), 32'd8);
    check("burst_first", 32'(first), 32'(c + 1));
    check("burst_last", 32'(last), 32'(c + 8));
    check("burst_fill0", 32'(fill_level), 32'd0);
    step(1);
    enable = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int  c;
    int  last;
    int  cnt;
    int  first;
    int  lst;
    bit  ok;

    #2;
    check("rst_data_i", 32'(rx_data_i), 32'd0);
    check("rst_data_q", 32'(rx_data_q), 32'd0);
    check("rst_valid", 32'(rx_data_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_under", 32'(underrun_cnt), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Period 25, four samples, then underruns every 25 cycles.
    init_pulse();
    period = 8'd25;
    for (int k = 1; k <= 4; k++) push(W'(k));
    enable = 1'b1;
    c = cyc;
    last = 0;
    for (int k = 1; k <= 4; k++) begin
      wait_valid("p25_pulse", 40, ok);
      if (ok) begin
        check("p25_data_i", 32'(rx_data_i), 32'(k));
        check("p25_data_q", 32'(rx_data_q), 32'(k ^ 12'hA5A));
        if (k == 1) check("p25_first_latency", 32'(cyc - c), 32'd25);
        else check("p25_spacing", 32'(cyc - last), 32'd25);
        last = cyc;
      end
    end
    check("p25_under0", 32'(underrun_cnt), 32'd0);
    repeat (25) @(negedge clk);
    check("p25_under1", 32'(underrun_cnt), 32'd1);
    repeat (25) @(negedge clk);
    check("p25_under2", 32'(underrun_cnt), 32'd2);
    step(1);
    enable = 1'b0;

    // Back-to-back pulses with period 0 and 1.
    burst(8'd0);
    burst(8'd1);

    // Fill to capacity, overflow push ignored, one pop reopens in_ready.
    init_pulse();
    period = 8'd3;
    for (int k = 0; k < 16; k++) push(W'(100 + k));
    check("full_fill", 32'(fill_level), 32'd16);
    check("full_ready", 32'(in_ready), 32'd0);
    push(W'(200));
    check("full_ignored", 32'(fill_level), 32'd16);
    enable = 1'b1;
    wait_valid("full_pop", 10, ok);
    if (ok) begin
      check("full_pop_data", 32'(rx_data_i), 32'd100);
      check("full_pop_ready", 32'(in_ready), 32'd1);
      check("full_pop_fill", 32'(fill_level), 32'd15);
    end
    step(1);
    enable = 1'b0;

    // Push coincident with a tick on an empty buffer.
    init_pulse();
    period = 8'd4;
    enable = 1'b1;
    c = cyc;
    step(3);
    in_i = 12'h03C;
    in_q = 12'h03C ^ 12'hA5A;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("coinc_under", 32'(underrun_cnt), 32'd1);
    check("coinc_fill", 32'(fill_level), 32'd1);
    wait_valid("coinc_pulse", 10, ok);
    if (ok) begin
      check("coinc_cycle", 32'(cyc - c), 32'd8);
      check("coinc_data", 32'(rx_data_i), 32'h03C);
    end
    step(1);
    enable = 1'b0;

    // Underrun saturation.
    init_pulse();
    period = 8'd1;
    enable = 1'b1;
    step(65534);
    check("sat_fffe", 32'(underrun_cnt), 32'hFFFE);
    step(3);
    check("sat_ffff", 32'(underrun_cnt), 32'hFFFF);
    enable = 1'b0;

    // sys_init with five buffered samples and a coincident push.
    init_pulse();
    for (int k = 0; k < 5; k++) push(W'(50 + k));
    check("init_fill5", 32'(fill_level), 32'd5);
    sys_init = 1'b1;
    in_i = 12'h777;
    in_valid = 1'b1;
    step(1);
    sys_init = 1'b0;
    in_valid = 1'b0;
    check("init_fill0", 32'(fill_level), 32'd0);
    check("init_valid0", 32'(rx_data_valid), 32'd0);
    check("init_under0", 32'(underrun_cnt), 32'd0);
    period = 8'd1;
    enable = 1'b1;
    count_valids(10, cnt, first, lst);
    check("init_no_stale", 32'(cnt), 32'd0);
    step(1);
    enable = 1'b0;

    // Asynchronous reset mid-stream.
    period = 8'd3;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) push(W'(80 + k));
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fill", 32'(fill_level), 32'd0);
    check("arst_valid", 32'(rx_data_valid), 32'd0);
    check("arst_under", 32'(underrun_cnt), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_data", 32'(rx_data_i), 32'd0);
    step(1);
    rst_n = 1'b1;
    count_valids(20, cnt, first, lst);
    check("arst_no_stale", 32'(cnt), 32'd0);
    enable = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
